// File: rtl/rst_pkg.sv
// Shared definitions for the per-peripheral reset agent: FSM states,
// default timing constants and the shared counter width helper.
package rst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUIESCE = 3'd1,
        ST_HOLD    = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_ACK     = 3'd4
    } state_e;

    localparam int DEF_HOLD_CYCLES     = 16;
    localparam int DEF_SETTLE_CYCLES   = 4;
    localparam int DEF_QUIESCE_TIMEOUT = 64;

    // Bits needed for a down-counter loaded with (largest parameter - 1).
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/rst_agent.sv
// Per-peripheral reset agent: waits for bus quiescence (bounded), holds the
// peripheral in reset, lets it settle, then acknowledges the sequence.
module rst_agent
    import rst_pkg::*;
#(
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int QUIESCE_TIMEOUT = DEF_QUIESCE_TIMEOUT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rst_req_i,
    input  logic       periph_idle_i,
    output logic       periph_rst_no,
    output logic       busy_o,
    output logic       ack_o,
    output logic       timeout_o,
    output logic [7:0] rst_count_o
);

    localparam int CW = cnt_width(HOLD_CYCLES, SETTLE_CYCLES, QUIESCE_TIMEOUT);

    localparam logic [CW-1:0] Q_LOAD = CW'(QUIESCE_TIMEOUT - 1);
    localparam logic [CW-1:0] H_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] S_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          to_q, to_d;
    logic [7:0]    count_q, count_d;
    logic          prst_n_q, prst_n_d;

    // Next-state, counter, pending/timeout flags and completion count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        to_d    = to_q;
        count_d = count_q;

        if ((state_q != ST_IDLE) && rst_req_i) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (rst_req_i) begin
                    state_d = ST_QUIESCE;
                    cnt_d   = Q_LOAD;
                    to_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_QUIESCE: begin
                if (periph_idle_i) begin
                    state_d = ST_HOLD;
                    cnt_d   = H_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = H_LOAD;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_SETTLE;
                    cnt_d   = S_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_ACK: begin
                if (count_q != 8'd255) begin
                    count_d = count_q + 8'd1;
                end else begin
                    count_d = count_q;
                end
                // A request landing in the ACK cycle itself chains straight on.
                if (pend_q || rst_req_i) begin
                    state_d = ST_QUIESCE;
                    cnt_d   = Q_LOAD;
                    to_d    = 1'b0;
                    pend_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    pend_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                pend_d  = 1'b0;
                to_d    = 1'b0;
            end
        endcase

        prst_n_d = (state_d != ST_HOLD);
    end

    // State and datapath registers; reset drives the peripheral reset low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            to_q     <= 1'b0;
            count_q  <= 8'd0;
            prst_n_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            to_q     <= to_d;
            count_q  <= count_d;
            prst_n_q <= prst_n_d;
        end
    end

    assign periph_rst_no = prst_n_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign ack_o         = (state_q == ST_ACK);
    assign timeout_o     = (state_q == ST_ACK) && to_q;
    assign rst_count_o   = count_q;

endmodule

// File: tb/tb_rst_agent.sv
// Self-checking bench for rst_agent: a timeline model of reset sequences is
// compared every cycle, plus literal checks at hand-computed cycles.
module tb_rst_agent;

    localparam int H  = 16;
    localparam int S  = 4;
    localparam int QT = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       idle = 1'b1;
    logic       prst_n, busy, ack, tmo;
    logic [7:0] cnt;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int acks    = 0;

    // Model: a sequence is described by when quiesce began and when hold began.
    bit m_active, m_pend, m_to, m_pre_edge;
    int m_qstart, m_hold, m_count;

    rst_agent dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rst_req_i    (req),
        .periph_idle_i(idle),
        .periph_rst_no(prst_n),
        .busy_o       (busy),
        .ack_o        (ack),
        .timeout_o    (tmo),
        .rst_count_o  (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_pend = 0; m_to = 0; m_pre_edge = 1;
        m_qstart = 0; m_hold = -1; m_count = 0;
    endtask

    task automatic model_step(input int e, input bit r, input bit idl);
        m_pre_edge = 0;
        if (!m_active) begin
            if (r) begin
                m_active = 1; m_qstart = e + 1; m_hold = -1; m_to = 0;
            end
        end else begin
            if (r) m_pend = 1;
            if (m_hold < 0) begin
                if (idl || (e - m_qstart + 1 == QT)) begin
                    m_hold = e + 1;
                    m_to   = !idl;
                end
            end else if (e == m_hold + H + S) begin
                if (m_count < 255) m_count++;
                if (m_pend) begin
                    m_qstart = e + 1; m_hold = -1; m_to = 0; m_pend = 0;
                end else begin
                    m_active = 0;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else model_step(cyc, req, idle);
            cyc++;
        end
    end

    initial forever begin
        @(posedge rst);
        model_reset();
    end

    // Per-cycle comparison against the model.
    initial forever begin
        bit in_hold, e_ack;
        @(negedge clk);
        in_hold = m_active && (m_hold >= 0) && (cyc >= m_hold) && (cyc < m_hold + H);
        e_ack   = m_active && (m_hold >= 0) && (cyc == m_hold + H + S);
        check("model_periph_rst_no", prst_n, !(m_pre_edge || in_hold));
        check("model_busy", busy, m_active);
        check("model_ack", ack, e_ack);
        check("model_timeout", tmo, e_ack && m_to);
        check("model_count", cnt, m_count);
        if (ack) acks++;
    end

    task automatic wait_cyc(input int n);
        if (cyc > n) begin
            errors++;
            $display("FAIL wait_cyc: already at cycle %0d, wanted %0d", cyc, n);
        end
        while (cyc < n) @(negedge clk);
    endtask

    task automatic req_at(input int n);
        wait_cyc(n);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, a0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_rstn_before_edge", prst_n, 0);
        @(negedge clk);
        check("rstn_after_release", prst_n, 1);
        check("busy_after_release", busy, 0);

        // Single request, peripheral idle.
        b = cyc + 2;
        req_at(b);
        wait_cyc(b + 1);  check("t1_busy_q", busy, 1); check("t1_rstn_q", prst_n, 1);
        wait_cyc(b + 2);  check("t1_rstn_first_low", prst_n, 0);
        wait_cyc(b + 17); check("t1_rstn_last_low", prst_n, 0);
        wait_cyc(b + 18); check("t1_rstn_high", prst_n, 1);
        wait_cyc(b + 22); check("t1_ack", ack, 1); check("t1_timeout", tmo, 0);
        wait_cyc(b + 23); check("t1_count", cnt, 1); check("t1_idle", busy, 0);

        // Peripheral never idle: quiesce times out.
        idle = 1'b0;
        b = cyc + 2;
        req_at(b);
        wait_cyc(b + 64); check("t2_still_quiesce", prst_n, 1);
        wait_cyc(b + 65); check("t2_hold", prst_n, 0);
        wait_cyc(b + 85); check("t2_ack", ack, 1); check("t2_timeout", tmo, 1);
        wait_cyc(b + 86); check("t2_count", cnt, 2);
        idle = 1'b1;

        // Requests during HOLD and SETTLE merge into one follow-on sequence.
        b = cyc + 2;
        a0 = acks;
        req_at(b);
        req_at(b + 5);
        req_at(b + 19);
        wait_cyc(b + 22); check("t3_ack1", ack, 1);
        wait_cyc(b + 23); check("t3_chain_busy", busy, 1); check("t3_chain_rstn", prst_n, 1);
        wait_cyc(b + 24); check("t3_chain_hold", prst_n, 0);
        wait_cyc(b + 44); check("t3_ack2", ack, 1);
        wait_cyc(b + 50); check("t3_ack_pulses", acks - a0, 2); check("t3_count", cnt, 4);
        check("t3_idle", busy, 0);

        // Request coincident with the ACK cycle.
        b = cyc + 2;
        req_at(b);
        req_at(b + 22);
        wait_cyc(b + 23); check("t4_quiesce_busy", busy, 1);
        wait_cyc(b + 44); check("t4_ack2", ack, 1);
        wait_cyc(b + 45); check("t4_count", cnt, 6);

        // Idle arrives mid-quiesce; later idle changes are ignored.
        idle = 1'b0;
        b = cyc + 2;
        req_at(b);
        wait_cyc(b + 10); idle = 1'b1;
        wait_cyc(b + 11); check("t5_hold", prst_n, 0);
        wait_cyc(b + 15); idle = 1'b0;
        wait_cyc(b + 31); check("t5_ack", ack, 1); check("t5_timeout", tmo, 0);
        wait_cyc(b + 32); check("t5_count", cnt, 7);
        idle = 1'b1;

        // Reset pulsed during HOLD with a request pending.
        b = cyc + 2;
        a0 = acks;
        req_at(b);
        req_at(b + 3);
        wait_cyc(b + 6);
        #2 rst = 1'b1;
        @(negedge clk);
        check("t6_rstn_in_reset", prst_n, 0); check("t6_busy_in_reset", busy, 0);
        check("t6_count_in_reset", cnt, 0); check("t6_ack_in_reset", ack, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("t6_rstn_after", prst_n, 1); check("t6_busy_after", busy, 0);
        repeat (30) @(negedge clk);
        check("t6_no_ack", acks - a0, 0); check("t6_no_pending", busy, 0);
        check("t6_count", cnt, 0);

        // 300 back-to-back sequences: count saturates.
        req = 1'b1;
        repeat (300 * 22) @(negedge clk);
        req = 1'b0;
        repeat (40) @(negedge clk);
        check("t7_saturated", cnt, 255);
        check("t7_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
